// File: rtl/csa_resolve_avg.sv
// Resolves a carry-save (sum, carry) pair to a binary total over a 2-stage split carry chain
// and derives the saturated 4-neighbour average. Optional macro CSA_ROUND_EN selects round-half-up.
module csa_resolve_avg #(
  parameter int W_IN    = 7,
  parameter int SPLIT   = 4,
  parameter int MAX_SUM = 124
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W_IN-1:0] in_sum,
  input  logic [W_IN-1:0] in_carry,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W_IN:0]   out_total,
  output logic [W_IN-3:0] out_avg,
  output logic            out_err,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int HW = W_IN - SPLIT;
  localparam int AW = W_IN - 2;

  logic            adv1, adv2;
  logic            s1_valid_q, s2_valid_q;
  logic [SPLIT-1:0] s1_lo_q;
  logic            s1_c1_q;
  logic [HW-1:0]   s1_hi_sum_q, s1_hi_carry_q;
  logic [W_IN:0]   total_q;
  logic [AW-1:0]   avg_q;
  logic            err_q;

  logic [SPLIT:0]  lo_d;
  logic [HW:0]     hi_d;
  logic [W_IN:0]   total_d;
  logic [W_IN-1:0] avg_full;
  logic [AW-1:0]   avg_d;
  logic            err_d;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    lo_d    = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
    hi_d    = {1'b0, s1_hi_sum_q} + {1'b0, s1_hi_carry_q} + {{HW{1'b0}}, s1_c1_q};
    total_d = {hi_d, s1_lo_q};
    err_d   = total_d > (W_IN+1)'(MAX_SUM);
`ifdef CSA_ROUND_EN
    avg_full = W_IN'(({1'b0, total_d} + (W_IN+2)'(2)) >> 2);
`else
    avg_full = W_IN'(total_d >> 2);
`endif
    // The +2 rounding can push the quotient past the output width; clamp to all ones.
    if (err_d || (avg_full > {2'b00, {AW{1'b1}}})) begin
      avg_d = {AW{1'b1}};
    end else begin
      avg_d = avg_full[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c1_q       <= 1'b0;
      s1_hi_sum_q   <= '0;
      s1_hi_carry_q <= '0;
    end else if (adv1) begin
      s1_valid_q    <= in_valid;
      s1_lo_q       <= lo_d[SPLIT-1:0];
      s1_c1_q       <= lo_d[SPLIT];
      s1_hi_sum_q   <= in_sum[W_IN-1:SPLIT];
      s1_hi_carry_q <= in_carry[W_IN-1:SPLIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      total_q    <= '0;
      avg_q      <= '0;
      err_q      <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        total_q <= total_d;
        avg_q   <= avg_d;
        err_q   <= err_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_total = total_q;
  assign out_avg   = avg_q;
  assign out_err   = err_q;

endmodule

// File: doc/csa_resolve_avg.md
Name: csa_resolve_avg

Overview:
- Consumer end of the 4-operand carry-save compressor used in the demosaicing neighbour-sum path.
- Accepts the redundant (sum vector, carry vector) pair and resolves it to a binary total with a 2-stage carry-propagate pipeline split at bit SPLIT.
- Also produces the 4-neighbour average for bilinear interpolation, with a valid/ready stream on both sides.

Parameters:
- W_IN, 7, width of each redundant input vector.
- SPLIT, 4, width of the low segment resolved in stage 1; the high segment (W_IN-SPLIT bits) is resolved in stage 2.
- MAX_SUM, 124, largest legal total (4 x 31); anything above is flagged as an error.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_sum  input  W_IN  carry-save sum vector.
- in_carry  input  W_IN  carry-save carry vector, already weight-aligned with in_sum.
- in_valid  input  1  input pair present.
- in_ready  output  1  block accepts the pair this cycle.
- out_total  output  W_IN+1  binary in_sum+in_carry.
- out_avg  output  W_IN-2  average of 4 = total/4, rounding per CSA_ROUND_EN, saturated.
- out_err  output  1  out_total > MAX_SUM.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Interface decided: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: s1_valid=0, s2_valid=0; out_valid=0, in_ready=1, out_total=0, out_avg=0, out_err=0.
- Reset mid-operation discards all in-flight beats; nothing is replayed after release.
- Handshake:
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational).
  - Transfer occurs on in_valid & in_ready, or out_valid & out_ready.
- Stage 1 (on adv1):
  - Load lo = in_sum[SPLIT-1:0] + in_carry[SPLIT-1:0], keeping SPLIT bits plus carry c1.
  - Also load the high slices of both vectors; s1_valid <= in_valid.
- Stage 2 (on adv2 & s1_valid):
  - total = {hi_sum + hi_carry + c1, lo}, W_IN+1 bits, no truncation (max 254).
  - err = total > MAX_SUM.
  - avg = rounded total>>2; if err or the result exceeds 2^(W_IN-2)-1, avg = all ones (31).
  - Register all three; s2_valid <= 1.
- s2_valid clears on out_ready when stage 1 has nothing to pass down.
- Latency: 2 cycles from accepted input to out_valid with no stall; throughput 1 beat/cycle.
- Stall: while out_valid & !out_ready, out_total, out_avg and out_err hold stable. Stage 1 still fills if empty; in_ready falls only when both stages are full.
- Ordering strictly preserved; no beat is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- in_sum and in_carry are don't-care when in_valid=0; the valid bit is never registered from X.

Optional Feature:
- CSA_ROUND_EN defined: avg = (total + 2) >> 2, round-half-up.
- Not defined: avg = total >> 2, truncation, and the +2 adder is removed.
- Saturation and err apply identically in both builds.

Test Plan:
- in_sum=60, in_carry=64, out_ready=1 -> 2 cycles later out_total=124, out_avg=31, out_err=0.
- in_sum=15, in_carry=1 (carry crosses SPLIT) -> out_total=16, out_avg=4, out_err=0.
- in_sum=1, in_carry=1 -> out_total=2; out_avg=1 with CSA_ROUND_EN, out_avg=0 without.
- in_sum=127, in_carry=127 -> out_total=254, out_err=1, out_avg=31 (saturated).
- Back-to-back beats with totals 10, 20, 30 and out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts; the third beat is held by the source; outputs stay frozen on 10.
  - After out_ready=1, outputs 10, 20, 30 appear on consecutive cycles.
- Pulse rst_n low for 1 cycle with 2 beats in flight -> out_valid=0 immediately (async); no stale beat appears after release.
